// File: rtl/car_pkg.sv
// Shared car-table definitions used by the broadcaster and the collision detector.
package car_pkg;
    localparam int unsigned NUM_CARS    = 12;
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned POS_W       = 10;
    localparam int unsigned ORIENT_BITS = 2;
    localparam int unsigned GRID_PITCH  = 160;

    typedef enum logic [ORIENT_BITS-1:0] {
        ORIENT_E = 2'd0,
        ORIENT_S = 2'd1,
        ORIENT_W = 2'd2,
        ORIENT_N = 2'd3
    } orient_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SEND   = 2'd2
    } bcastState_t;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        orient_t          orient;
    } carEntry_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        orient_t          orient;
    } carRecord_t;

    // Cars start on a 4-wide grid; orientation cycles E,S,W,N along each row.
    function automatic carEntry_t resetEntry(input logic [IDX_W-1:0] idx);
        carEntry_t e;
        e.x      = POS_W'(32'(idx[1:0]) * GRID_PITCH);
        e.y      = POS_W'(32'(idx[3:2]) * GRID_PITCH);
        e.orient = orient_t'(idx[1:0]);
        return e;
    endfunction
endpackage

// File: rtl/car_step.sv
// Combinational one-step advance of a car position with screen-edge wrap-around.
module car_step #(
    parameter int unsigned SCREEN_W = car_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = car_pkg::SCREEN_H,
    parameter int unsigned STEP     = 1
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [1:0] orient,
    output logic [9:0] nextX_c,
    output logic [9:0] nextY_c
);
    import car_pkg::*;

    localparam int unsigned EXT_W = 11;

    logic [EXT_W-1:0] xFwd;
    logic [EXT_W-1:0] yFwd;

    assign xFwd = EXT_W'(x) + EXT_W'(STEP);
    assign yFwd = EXT_W'(y) + EXT_W'(STEP);

    always_comb begin
        nextX_c = x;
        nextY_c = y;
        case (orient)
            ORIENT_E: nextX_c = (xFwd >= EXT_W'(SCREEN_W)) ? POS_W'(xFwd - EXT_W'(SCREEN_W)) : POS_W'(xFwd);
            ORIENT_S: nextY_c = (yFwd >= EXT_W'(SCREEN_H)) ? POS_W'(yFwd - EXT_W'(SCREEN_H)) : POS_W'(yFwd);
            ORIENT_W: nextX_c = (x < POS_W'(STEP)) ? POS_W'(EXT_W'(x) + EXT_W'(SCREEN_W) - EXT_W'(STEP))
                                                   : POS_W'(x - POS_W'(STEP));
            default:  nextY_c = (y < POS_W'(STEP)) ? POS_W'(EXT_W'(y) + EXT_W'(SCREEN_H) - EXT_W'(STEP))
                                                   : POS_W'(y - POS_W'(STEP));
        endcase
    end
endmodule

// File: rtl/car_state_broadcaster.sv
// Owns the car position table: advances all cars each game tick, then streams
// the updated records to the collision detector over a valid/ready handshake.
module car_state_broadcaster #(
    parameter int unsigned NUM_CARS = car_pkg::NUM_CARS,
    parameter int unsigned SCREEN_W = car_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = car_pkg::SCREEN_H,
    parameter int unsigned STEP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       halt,
    output logic       car_valid,
    input  logic       car_ready,
    output logic [3:0] car_index,
    output logic [9:0] car_x,
    output logic [9:0] car_y,
    output logic [1:0] car_orient,
    output logic       busy,
    output logic       frame_done,
    output logic       tick_overrun
);
    import car_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

    bcastState_t      state, stateNext;
    carEntry_t        carTable [NUM_CARS];
    logic [IDX_W-1:0] updIdx, updIdxNext;
    logic [IDX_W-1:0] sendIdx, sendIdxNext;
    logic             pending, pendingNext;
    logic             frozen, frozenNext;
    logic             overrunNext, validNext, busyNext, frameDoneNext;
    logic             tableWrite;
    carRecord_t       outRec, outRecNext;
    carEntry_t        updEntry, stepEntry;
    logic [POS_W-1:0] stepX, stepY;

    assign updEntry = carTable[updIdx];

    car_step #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H),
        .STEP    (STEP)
    ) u_step (
        .x      (updEntry.x),
        .y      (updEntry.y),
        .orient (updEntry.orient),
        .nextX_c(stepX),
        .nextY_c(stepY)
    );

    assign stepEntry = '{x: stepX, y: stepY, orient: updEntry.orient};

    // Next-state, bookkeeping and registered-output values.
    always_comb begin
        stateNext     = state;
        updIdxNext    = updIdx;
        sendIdxNext   = sendIdx;
        pendingNext   = pending;
        frozenNext    = frozen;
        overrunNext   = tick_overrun;
        frameDoneNext = 1'b0;
        tableWrite    = 1'b0;
        outRecNext    = outRec;

        // A tick while busy is queued once; any further one is dropped.
        if (state != IDLE && tick) begin
            if (pending) overrunNext = 1'b1;
            else         pendingNext = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (tick || pending) begin
                    stateNext   = UPDATE;
                    pendingNext = 1'b0;
                    frozenNext  = halt;
                    updIdxNext  = '0;
                end
            end
            UPDATE: begin
                tableWrite = 1'b1;
                updIdxNext = updIdx + IDX_W'(1);
                if (updIdx == LAST_IDX) begin
                    stateNext   = SEND;
                    sendIdxNext = '0;
                end
            end
            SEND: begin
                if (car_valid && car_ready) begin
                    if (sendIdx == LAST_IDX) begin
                        stateNext     = IDLE;
                        frameDoneNext = 1'b1;
                    end else begin
                        sendIdxNext = sendIdx + IDX_W'(1);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        validNext = (stateNext == SEND);
        busyNext  = (stateNext != IDLE);
        if (stateNext == SEND) begin
            outRecNext.index  = sendIdxNext;
            outRecNext.x      = carTable[sendIdxNext].x;
            outRecNext.y      = carTable[sendIdxNext].y;
            outRecNext.orient = carTable[sendIdxNext].orient;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            updIdx       <= '0;
            sendIdx      <= '0;
            pending      <= 1'b0;
            frozen       <= 1'b0;
            tick_overrun <= 1'b0;
            car_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            outRec       <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                carTable[i] <= resetEntry(IDX_W'(i));
            end
        end else begin
            state        <= stateNext;
            updIdx       <= updIdxNext;
            sendIdx      <= sendIdxNext;
            pending      <= pendingNext;
            frozen       <= frozenNext;
            tick_overrun <= overrunNext;
            car_valid    <= validNext;
            busy         <= busyNext;
            frame_done   <= frameDoneNext;
            outRec       <= outRecNext;
            if (tableWrite && !frozen) begin
                carTable[updIdx] <= stepEntry;
            end
        end
    end

    assign car_index  = outRec.index;
    assign car_x      = outRec.x;
    assign car_y      = outRec.y;
    assign car_orient = outRec.orient;
endmodule
